// File: rtl/inst_rom_loader.sv
// Program store for the 4-bit CPU: byte-serial load via valid/ready, async read of mem[pc].
// Latency: inst follows pc combinationally in RUN; cpu_reset is registered (falls on the edge entering RUN).
// Backpressure: load_ready is high only in LOAD; bytes offered in any other state are dropped.
module inst_rom_loader #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int RST_HOLD = 4
) (
  input  logic          clk_cpu,
  input  logic          reset,
  input  logic          load_start,
  input  logic [DW-1:0] load_data,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] inst,
  output logic          cpu_reset,
  output logic          loaded
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [AW-1:0] WPTR_LAST = AW'(DEPTH - 1);
  localparam logic [3:0]    HOLD_LAST = 4'(RST_HOLD - 1);

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] wptr;
  logic [3:0]    hold_cnt;
  logic [DW-1:0] mem [DEPTH];
  logic          accept;

  // A byte is only ever taken while loading; load_start has no say here.
  assign accept = (state == LOAD) && load_valid;

  // Next-state decode; cpu_reset is derived from it so it drops on the same edge RUN is entered.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (load_start) next_state = LOAD;
      LOAD: if (accept && (wptr == WPTR_LAST)) next_state = HOLD;
      HOLD: if (hold_cnt == HOLD_LAST) next_state = RUN;
      RUN:  if (load_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // Control state: FSM, write pointer, hold counter and the registered CPU reset.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      hold_cnt  <= '0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= next_state;
      cpu_reset <= (next_state != RUN);
      case (state)
        IDLE, RUN: begin
          if (load_start) wptr <= '0;
        end
        LOAD: begin
          if (accept) begin
            // Natural wrap takes wptr back to 0 after the last word.
            wptr <= wptr + 1'b1;
            if (wptr == WPTR_LAST) hold_cnt <= '0;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Program memory: wiped on reset so a partially loaded image can never execute.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wptr] <= load_data;
    end
  end

  assign load_ready = (state == LOAD);
  assign loaded     = (state == RUN);
  assign inst       = (state == RUN) ? mem[pc] : '0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: randomized pc/data/gaps checked against a program-level reference model.
// Latency: model advances once per posedge; DUT outputs compared at the following negedge.
// Backpressure: every load loop is bounded; a load that never completes is reported and the run continues.
module tb_inst_rom_loader;

  localparam int RST_HOLD = 4;

  logic       clk_cpu    = 1'b0;
  logic       reset      = 1'b1;
  logic       load_start = 1'b0;
  logic [7:0] load_data  = 8'h00;
  logic       load_valid = 1'b0;
  logic [3:0] pc         = 4'h0;
  logic       load_ready;
  logic [7:0] inst;
  logic       cpu_reset;
  logic       loaded;

  inst_rom_loader #(
    .DEPTH(16), .AW(4), .DW(8), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk_cpu    (clk_cpu),
    .reset      (reset),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pc         (pc),
    .inst       (inst),
    .cpu_reset  (cpu_reset),
    .loaded     (loaded)
  );

  always #50 clk_cpu = ~clk_cpu;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: program image, whether a load is collecting bytes,
  // how many bytes it has, hold cycles still to go, and whether the CPU runs.
  logic [7:0] m_mem [16];
  bit         m_loading;
  bit         m_run;
  int         m_cnt;
  int         m_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_loading = 0;
    m_run     = 0;
    m_cnt     = 0;
    m_hold    = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (m_loading) begin
      if (load_valid) begin
        m_mem[m_cnt] = load_data;
        m_cnt++;
        if (m_cnt == 16) begin
          m_loading = 0;
          m_hold    = RST_HOLD;
        end
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_run = 1;
    end else if (load_start) begin
      m_loading = 1;
      m_cnt     = 0;
      m_run     = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ready"},     {31'd0, load_ready}, {31'd0, m_loading});
    check({tag, ".loaded"},    {31'd0, loaded},     {31'd0, m_run});
    check({tag, ".cpu_reset"}, {31'd0, cpu_reset},  {31'd0, !m_run});
    check({tag, ".inst"},      {24'd0, inst},       m_run ? {24'd0, m_mem[pc]} : 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk_cpu);
    model_edge();
    @(negedge clk_cpu);
    check_outputs("cyc");
  endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
    pc = a;
    #1;
    check(tag, {24'd0, inst}, {24'd0, exp});
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      pc = 4'(a);
      #1;
      check(tag, {24'd0, inst}, m_run ? {24'd0, m_mem[a]} : 32'd0);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps and random data
  task automatic feed(input logic [7:0] base, input int mode, input bit keep_start,
                      output int ready_cnt, output int span);
    int idx;
    int k;
    int first;
    int last;
    bit v;
    idx = 0; k = 0; first = -1; last = -1;
    ready_cnt  = 0;
    load_start = keep_start;
    while (m_loading && k < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (load_ready) ready_cnt++;
      load_valid = v;
      load_data  = (mode == 2) ? 8'($urandom) : base + 8'(idx);
      pc         = 4'($urandom);
      if (v) begin
        if (first < 0) first = k;
        last = k;
        idx++;
      end
      cycle();
      k++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    if (m_loading) check("load_timeout", 32'd1, 32'd0);
    span = last - first + 1;
  endtask

  task automatic wait_run(output int edges);
    int g;
    g = 0;
    edges = 1;
    while (cpu_reset && g < 20) begin
      pc = 4'($urandom);
      cycle();
      edges++;
      g++;
    end
    if (cpu_reset) check("hold_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int rc;
    int sp;
    int edges;
    model_reset();

    // Reset held for 5 cycles with pc swept: CPU held, nothing visible.
    repeat (5) begin
      @(negedge clk_cpu);
      for (int a = 0; a < 16; a++) begin
        pc = 4'(a);
        #1;
        check("rst.inst", {24'd0, inst}, 32'd0);
      end
      check("rst.cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rst.ready",     {31'd0, load_ready}, 32'd0);
      check("rst.loaded",    {31'd0, loaded}, 32'd0);
    end
    reset = 1'b0;

    // Bytes offered in IDLE are dropped.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    repeat (3) cycle();
    load_valid = 1'b0;

    // Full back-to-back load of 0x30..0x3F.
    start_load();
    feed(8'h30, 0, 1'b0, rc, sp);
    check("full.ready_cycles", rc, 16);
    wait_run(edges);
    check("full.reset_fall_edges", edges, RST_HOLD + 1);
    check("full.loaded", {31'd0, loaded}, 32'd1);
    peek("full.pc5", 4'h5, 8'h35);
    peek("full.pcF", 4'hF, 8'h3F);
    sweep("full.sweep");

    // Reload with valid every other cycle: same image, 31-cycle span.
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h30 + 8'(i);
    start_load();
    feed(8'h30, 1, 1'b0, rc, sp);
    check("gap.span", sp, 31);
    wait_run(edges);
    peek("gap.pc5", 4'h5, 8'h35);
    sweep("gap.sweep");

    // Reset after 7 accepted bytes: back to IDLE with memory cleared.
    start_load();
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h50 + 8'(i);
      cycle();
    end
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check("rstmid.cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rstmid.ready",     {31'd0, load_ready}, 32'd0);
    check("rstmid.loaded",    {31'd0, loaded}, 32'd0);
    cycle();
    reset = 1'b0;
    cycle();
    start_load();
    feed(8'hB0, 0, 1'b0, rc, sp);
    wait_run(edges);
    peek("rstmid.pc3", 4'h3, 8'hB3);

    // Reprogram from RUN; a byte offered with load_start is not written.
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    cycle();
    load_start = 1'b0;
    load_valid = 1'b0;
    check("rp.cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rp.loaded",    {31'd0, loaded}, 32'd0);
    check("rp.inst",      {24'd0, inst}, 32'd0);
    feed(8'h80, 0, 1'b0, rc, sp);
    wait_run(edges);
    peek("rp.pc0", 4'h0, 8'h80);
    sweep("rp.sweep");

    // load_start held high during LOAD is ignored: bytes land at 0..F.
    start_load();
    feed(8'hC0, 0, 1'b1, rc, sp);
    wait_run(edges);
    for (int a = 0; a < 16; a++) peek("hold_start.img", 4'(a), 8'hC0 + 8'(a));

    // Random loads with random gaps, then random RUN traffic without load_start.
    for (int r = 0; r < 4; r++) begin
      start_load();
      feed(8'h00, 2, 1'($urandom), rc, sp);
      check("rand.ready_cycles", rc, sp + ((rc - sp) > 0 ? (rc - sp) : 0));
      wait_run(edges);
      check("rand.reset_fall_edges", edges, RST_HOLD + 1);
      for (int c = 0; c < 10; c++) begin
        pc         = 4'($urandom);
        load_valid = 1'($urandom);
        load_data  = 8'($urandom);
        cycle();
      end
      load_valid = 1'b0;
      sweep("rand.sweep");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
